kathryn_seq_count_top: RTL and testbench

//  Top-level sequential controller with three phases: a fixed start-up wait, a counting loop,
//  and a terminal done state. While busy it drives a running count (a), a wrapping sub-phase

---
 rtl/kathryn_seq_count_top_if.sv | 25 ++
 rtl/kathryn_seq_count_top.sv | 128 ++++++++++++
 tb/tb_kathryn_seq_count_top.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/kathryn_seq_count_top_if.sv
// Output bundle of the sequence counter: running count, done flag,
// sub-phase count and busy flag. The counter drives it (master) and
// any observer samples it (slave).
interface kathryn_seq_count_top_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] c;
   logic             d;

   modport master (
      output a,
      output b,
      output c,
      output d
   );

   modport slave (
      input a,
      input b,
      input c,
      input d
   );
endinterface

// File: rtl/kathryn_seq_count_top.sv
// Self-running sequence controller: a fixed start-up wait, a counting loop
// that advances a by STEP and c modulo C_MOD, then a terminal done state.
// No data inputs; behaviour depends only on clk and the active-low async rst.
module kathryn_seq_count_top #(
   parameter int WIDTH       = 8,
   parameter int WAIT_CYCLES = 6,
   parameter int LIMIT       = 48,
   parameter int STEP        = 1,
   parameter int C_MOD       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   kathryn_seq_count_top_if.master bus
);

   // Wait counter only has to reach WAIT_CYCLES-1, so it needs at least one bit.
   localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   localparam logic [WCW-1:0]   WAIT_LAST = WCW'(WAIT_CYCLES - 1);
   localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
   localparam logic [WIDTH:0]   LIMIT_W   = (WIDTH + 1)'(LIMIT);
   localparam logic [WIDTH-1:0] LIMIT_N   = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] C_MASK    = WIDTH'(C_MOD - 1);
   localparam logic             LIMIT_IS0 = (LIMIT == 0);

   typedef enum logic [1:0] {
      ST_WAIT = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;

   // One bit wider than a so the terminal compare can never be fooled by a wrap.
   logic [WIDTH:0]   a_sum;

   // Register all state and outputs; rst low forces the reset values at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_WAIT;
         wait_cnt_q <= '0;
         a_q        <= '0;
         c_q        <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         a_q        <= a_d;
         c_q        <= c_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and next-output logic; everything holds unless a phase changes it.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      a_d        = a_q;
      c_d        = c_q;
      done_d     = done_q;
      busy_d     = busy_q;
      a_sum      = {1'b0, a_q} + STEP_W;

      unique case (state_q)
         ST_WAIT: begin
            a_d    = '0;
            c_d    = '0;
            done_d = 1'b0;
            busy_d = 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
               wait_cnt_d = '0;
               if (LIMIT_IS0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + WCW'(1);
            end
         end

         ST_RUN: begin
            if (a_sum == LIMIT_W) begin
               state_d = ST_DONE;
               a_d     = LIMIT_N;
               c_d     = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               a_d    = a_sum[WIDTH-1:0];
               c_d    = (c_q + WIDTH'(1)) & C_MASK;
               busy_d = 1'b1;
            end
         end

         ST_DONE: begin
            a_d    = LIMIT_N;
            c_d    = '0;
            done_d = 1'b1;
            busy_d = 1'b0;
         end

         default: begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
            a_d        = '0;
            c_d        = '0;
            done_d     = 1'b0;
            busy_d     = 1'b1;
         end
      endcase
   end

   assign bus.a = a_q;
   assign bus.b = WIDTH'(done_q);
   assign bus.c = c_q;
   assign bus.d = busy_q;

endmodule

// File: tb/tb_kathryn_seq_count_top.sv
// Directed bench for the sequence counter: walks the wait, run and done
// phases at hand-computed edge numbers and checks asynchronous reset
// both mid-run and in the done state.
module tb_kathryn_seq_count_top;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   edge_num;
   logic [24:0] got;

   kathryn_seq_count_top_if #(.WIDTH(8)) bus ();

   kathryn_seq_count_top #(
      .WIDTH(8), .WAIT_CYCLES(6), .LIMIT(48), .STEP(1), .C_MOD(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to a given edge number after reset release, ending on a falling edge.
   task automatic advance_to(input int target);
      while (edge_num < target) begin
         @(posedge clk);
         edge_num++;
         @(negedge clk);
      end
   endtask

   // Release reset on a falling edge so the next rising edge is edge 1.
   task automatic release_reset();
      @(negedge clk);
      rst      = 1'b1;
      edge_num = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL reset_values got a=%0d b=%0d c=%0d d=%0b want a=0 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      release_reset();
   endtask

   task automatic test_wait();
      advance_to(5);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL wait_edge5 got a=%0d b=%0d c=%0d d=%0b want a=0 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(6);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL wait_edge6 got a=%0d b=%0d c=%0d d=%0b want a=0 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(7);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd1, 8'd0, 8'd1, 1'b1}) begin
         bad++;
         $display("[TB] FAIL run_edge7 got a=%0d b=%0d c=%0d d=%0b want a=1 b=0 c=1 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
   endtask

   task automatic test_run_mid();
      advance_to(30);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd24, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL run_edge30 got a=%0d b=%0d c=%0d d=%0b want a=24 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(31);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd25, 8'd0, 8'd1, 1'b1}) begin
         bad++;
         $display("[TB] FAIL run_edge31 got a=%0d b=%0d c=%0d d=%0b want a=25 b=0 c=1 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
   endtask

   task automatic test_done_boundary(input string tag);
      advance_to(53);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd47, 8'd0, 8'd3, 1'b1}) begin
         bad++;
         $display("[TB] FAIL %s_edge53 got a=%0d b=%0d c=%0d d=%0b want a=47 b=0 c=3 d=1",
                  tag, bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(54);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd48, 8'd1, 8'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL %s_edge54 got a=%0d b=%0d c=%0d d=%0b want a=48 b=1 c=0 d=0",
                  tag, bus.a, bus.b, bus.c, bus.d);
      end
   endtask

   task automatic test_done_hold();
      advance_to(56);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd48, 8'd1, 8'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL hold_edge56 got a=%0d b=%0d c=%0d d=%0b want a=48 b=1 c=0 d=0",
                  bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(155);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd48, 8'd1, 8'd0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL hold_edge155 got a=%0d b=%0d c=%0d d=%0b want a=48 b=1 c=0 d=0",
                  bus.a, bus.b, bus.c, bus.d);
      end
   endtask

   // Drop rst between clock edges and look before any rising edge arrives.
   task automatic pulse_async_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL %s got a=%0d b=%0d c=%0d d=%0b want a=0 b=0 c=0 d=1",
                  tag, bus.a, bus.b, bus.c, bus.d);
      end
      release_reset();
   endtask

   task automatic test_async_reset_run();
      advance_to(26);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd20, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL pre_abort_edge26 got a=%0d b=%0d c=%0d d=%0b want a=20 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      pulse_async_reset("abort_run");
      test_done_boundary("rerun");
   endtask

   task automatic test_async_reset_done();
      advance_to(60);
      pulse_async_reset("abort_done");
      advance_to(6);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd0, 8'd0, 8'd0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL after_done_edge6 got a=%0d b=%0d c=%0d d=%0b want a=0 b=0 c=0 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
      advance_to(8);
      got = {bus.a, bus.b, bus.c, bus.d};
      total++;
      if (got !== {8'd2, 8'd0, 8'd2, 1'b1}) begin
         bad++;
         $display("[TB] FAIL after_done_edge8 got a=%0d b=%0d c=%0d d=%0b want a=2 b=0 c=2 d=1",
                  bus.a, bus.b, bus.c, bus.d);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      total    = 0;
      bad      = 0;
      edge_num = 0;
      rst      = 1'b0;
      test_reset();
      test_wait();
      test_run_mid();
      test_done_boundary("first");
      test_done_hold();
      release_reset_from_done: begin
         rst = 1'b0;
         @(negedge clk);
         release_reset();
      end
      test_async_reset_run();
      test_async_reset_done();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
